// File: rtl/ahb_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : ahb_arbiter                                                |
// | Description : AHB bus arbiter. Round-robin grant between NUM_MASTERS     |
// |               requesters. Grants are held across fixed-length bursts and |
// |               locked sequences. The grant is parked on DEFAULT_MASTER    |
// |               when nobody requests.                                      |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
// | Ports                                                                    |
// |   HCLK      in   1            clock, all state on rising edge            |
// |   HRESETn   in   1            synchronous active-low reset               |
// |   HBUSREQ   in   NUM_MASTERS  per-master bus request                     |
// |   HLOCK     in   NUM_MASTERS  per-master locked-transfer request         |
// |   HTRANS    in   2            address-phase transfer type                |
// |   HBURST    in   3            address-phase burst type                   |
// |   HREADY    in   1            transfer complete                          |
// |   HGRANT    out  NUM_MASTERS  one-hot grant (registered)                 |
// |   HMASTER   out  4            address-phase owner index (registered)     |
// |   HMASTLOCK out  1            address phase is locked (registered)       |
// +--------------------------------------------------------------------------+
module ahb_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int DEFAULT_MASTER = 0
) (
  input  logic                   HCLK,
  input  logic                   HRESETn,
  input  logic [NUM_MASTERS-1:0] HBUSREQ,
  input  logic [NUM_MASTERS-1:0] HLOCK,
  input  logic [1:0]             HTRANS,
  input  logic [2:0]             HBURST,
  input  logic                   HREADY,
  output logic [NUM_MASTERS-1:0] HGRANT,
  output logic [3:0]             HMASTER,
  output logic                   HMASTLOCK
);

  localparam logic [1:0] c_TRANS_IDLE   = 2'd0;
  localparam logic [1:0] c_TRANS_BUSY   = 2'd1;
  localparam logic [1:0] c_TRANS_NONSEQ = 2'd2;
  localparam logic [1:0] c_TRANS_SEQ    = 2'd3;

  localparam logic [3:0] c_DEF_IDX = 4'(DEFAULT_MASTER);
  localparam logic [4:0] c_NUM     = 5'(NUM_MASTERS);
  localparam logic [NUM_MASTERS-1:0] c_DEF_ONEHOT =
    {{(NUM_MASTERS-1){1'b0}}, 1'b1} << DEFAULT_MASTER;

  typedef enum logic [1:0] {
    ST_DEFAULT   = 2'd0,
    ST_OWNED     = 2'd1,
    ST_LOCKED    = 2'd2,
    ST_LOCK_TAIL = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [4:0]             burst_left_q, burst_left_d;
  logic [3:0]             grant_idx_q, grant_idx_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [3:0]             hmaster_q;
  logic                   hmastlock_q;

  // Request/lock vectors widened to 16 so a 4-bit index is always legal.
  logic [15:0] w_req_ext;
  logic [15:0] w_lock_ext;
  logic        w_granted_lock;
  logic [4:0]  w_burst_load;
  logic        w_rr_found;
  logic [3:0]  w_rr_idx;
  logic [4:0]  w_scan;
  logic        w_arbitrate;

  assign w_req_ext      = 16'(HBUSREQ);
  assign w_lock_ext     = 16'(HLOCK);
  assign w_granted_lock = w_lock_ext[grant_idx_q];

  // Beats remaining after the first beat of a new burst.
  always_comb begin
    w_burst_load = 5'd0;
    case (HBURST)
      3'd2, 3'd3: w_burst_load = 5'd3;
      3'd4, 3'd5: w_burst_load = 5'd7;
      3'd6, 3'd7: w_burst_load = 5'd15;
      default:    w_burst_load = 5'd0;
    endcase
  end

  // Round-robin scan starting just after the current grantee; offset
  // NUM_MASTERS wraps back to the grantee itself, so it is tried last.
  // grant_idx + offset < 2*NUM_MASTERS, so one subtraction wraps it.
  always_comb begin
    w_rr_found = 1'b0;
    w_rr_idx   = c_DEF_IDX;
    w_scan     = 5'd0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      w_scan = {1'b0, grant_idx_q} + 5'(k);
      if (w_scan >= c_NUM) begin
        w_scan = w_scan - c_NUM;
      end
      if (!w_rr_found && w_req_ext[w_scan[3:0]]) begin
        w_rr_found = 1'b1;
        w_rr_idx   = w_scan[3:0];
      end
    end
  end

  // Next-state logic. HREADY low freezes everything.
  always_comb begin
    state_d      = state_q;
    grant_idx_d  = grant_idx_q;
    burst_left_d = burst_left_q;
    w_arbitrate  = 1'b0;

    if (HREADY) begin
      case (HTRANS)
        c_TRANS_NONSEQ: burst_left_d = w_burst_load;
        c_TRANS_SEQ:    burst_left_d = (burst_left_q == 5'd0) ? 5'd0
                                                               : burst_left_q - 5'd1;
        c_TRANS_IDLE:   burst_left_d = 5'd0;
        default:        burst_left_d = burst_left_q;
      endcase

      case (state_q)
        ST_DEFAULT, ST_OWNED: begin
          // A locked NONSEQ from the grantee takes priority over re-arbitration.
          if ((HTRANS == c_TRANS_NONSEQ) && w_granted_lock) begin
            state_d = ST_LOCKED;
          end else if ((HTRANS != c_TRANS_BUSY) && (burst_left_d == 5'd0)) begin
            w_arbitrate = 1'b1;
          end
        end
        ST_LOCKED: begin
          if (!w_granted_lock) begin
            state_d = ST_LOCK_TAIL;
          end
        end
        ST_LOCK_TAIL: begin
          if (HTRANS != c_TRANS_BUSY) begin
            w_arbitrate = 1'b1;
          end
        end
      endcase

      if (w_arbitrate) begin
        if (w_rr_found) begin
          grant_idx_d = w_rr_idx;
          state_d     = ST_OWNED;
        end else begin
          grant_idx_d = c_DEF_IDX;
          state_d     = ST_DEFAULT;
        end
      end
    end
  end

  always_comb begin
    grant_d = '0;
    for (int m = 0; m < NUM_MASTERS; m++) begin
      grant_d[m] = (grant_idx_d == 4'(m));
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q      <= ST_DEFAULT;
      burst_left_q <= 5'd0;
      grant_idx_q  <= c_DEF_IDX;
      grant_q      <= c_DEF_ONEHOT;
      hmaster_q    <= c_DEF_IDX;
      hmastlock_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      burst_left_q <= burst_left_d;
      grant_idx_q  <= grant_idx_d;
      grant_q      <= grant_d;
      // The current grantee takes over the address phase on HREADY.
      if (HREADY) begin
        hmaster_q   <= grant_idx_q;
        hmastlock_q <= w_granted_lock;
      end
    end
  end

  assign HGRANT    = grant_q;
  assign HMASTER   = hmaster_q;
  assign HMASTLOCK = hmastlock_q;

endmodule
`default_nettype wire
